// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared types, widths and helpers for the LCD capture block
// Capture states, counter width, saturating increment and CRC-16-CCITT byte step.
package lcd_pkg;

  localparam int              CNT_W    = 10;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [15:0]     CRC_POLY = 16'h1021;
  localparam logic [15:0]     CRC_INIT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // MSB-first byte update, one shift per data bit.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c_in, input logic [7:0] d);
    logic [15:0] c;
    c = c_in;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/lcd_timing_meter.sv
// rtl/lcd_timing_meter.sv - edge detection and frame timing measurement
// Inputs are the already-registered LCD syncs; counters saturate instead of wrapping.
module lcd_timing_meter
  import lcd_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_hs,
  input  logic             i_vs,
  input  logic             i_den,
  output logic             o_hs_fall,
  output logic             o_vs_fall,
  output logic             o_vs_rise,
  output logic             o_den_rise,
  output logic [CNT_W-1:0] o_h_total,
  output logic [CNT_W-1:0] o_h_active,
  output logic [CNT_W-1:0] o_v_total,
  output logic [CNT_W-1:0] o_v_active
);

  logic             r_hs_d, r_vs_d, r_den_d;
  logic             r_line_act;
  logic [CNT_W-1:0] r_h_cnt, r_h_act_cnt, r_v_cnt, r_v_act_cnt;
  logic [CNT_W-1:0] r_h_total, r_h_active, r_v_total, r_v_active;
  logic             w_hs_fall, w_vs_fall, w_pix;
  logic [CNT_W-1:0] w_v_act_next;

  assign w_hs_fall  = r_hs_d & ~i_hs;
  assign w_vs_fall  = r_vs_d & ~i_vs;
  assign w_pix      = ~i_den;
  assign o_hs_fall  = w_hs_fall;
  assign o_vs_fall  = w_vs_fall;
  assign o_vs_rise  = ~r_vs_d & i_vs;
  assign o_den_rise = ~r_den_d & i_den;

  // A line ending on this hsync fall is credited to the frame still open.
  assign w_v_act_next = (w_hs_fall && r_line_act) ? sat_inc(r_v_act_cnt) : r_v_act_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hs_d      <= 1'b1;
      r_vs_d      <= 1'b1;
      r_den_d     <= 1'b1;
      r_line_act  <= 1'b0;
      r_h_cnt     <= '0;
      r_h_act_cnt <= '0;
      r_v_cnt     <= '0;
      r_v_act_cnt <= '0;
      r_h_total   <= '0;
      r_h_active  <= '0;
      r_v_total   <= '0;
      r_v_active  <= '0;
    end else begin
      r_hs_d  <= i_hs;
      r_vs_d  <= i_vs;
      r_den_d <= i_den;

      if (w_hs_fall) begin
        r_h_total   <= sat_inc(r_h_cnt);
        r_h_cnt     <= '0;
        if (r_h_act_cnt != '0) r_h_active <= r_h_act_cnt;
        r_h_act_cnt <= {{(CNT_W-1){1'b0}}, w_pix};
        r_line_act  <= w_pix;
      end else begin
        r_h_cnt <= sat_inc(r_h_cnt);
        if (w_pix) begin
          r_h_act_cnt <= sat_inc(r_h_act_cnt);
          r_line_act  <= 1'b1;
        end
      end

      if (w_vs_fall) begin
        r_v_total   <= r_v_cnt;
        r_v_active  <= w_v_act_next;
        r_v_cnt     <= {{(CNT_W-1){1'b0}}, w_hs_fall};
        r_v_act_cnt <= '0;
      end else begin
        if (w_hs_fall) r_v_cnt <= sat_inc(r_v_cnt);
        r_v_act_cnt <= w_v_act_next;
      end
    end
  end

  assign o_h_total  = r_h_total;
  assign o_h_active = r_h_active;
  assign o_v_total  = r_v_total;
  assign o_v_active = r_v_active;

endmodule

// File: rtl/lcd_capture.sv
// rtl/lcd_capture.sv - LCD receive scope: timing meter, one-shot 1-bit frame grab, CPU readback
// Optional CAPTURE_CRC_EN adds a CRC-16-CCITT over raw active pixels of the captured frame.
module lcd_capture
  import lcd_pkg::*;
#(
  parameter logic [7:0] THRESH     = 8'h80,
  parameter int         LINE_BYTES = 40,
  parameter int         RAM_DEPTH  = 2048
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [7:0]       lcd_dat,
  input  logic             lcd_hsync,
  input  logic             lcd_vsync,
  input  logic             lcd_den,
  input  logic             arm,
  output logic             busy,
  output logic             frame_done,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] h_active,
  output logic [CNT_W-1:0] v_total,
  output logic [CNT_W-1:0] v_active,
  input  logic             rd_cap,
  input  logic [10:0]      addr,
  output logic [7:0]       cap_out,
  output logic [15:0]      crc
);

  localparam int               AW        = $clog2(RAM_DEPTH);
  localparam logic [CNT_W-1:0] LINE_PX   = CNT_W'(LINE_BYTES * 8);
  localparam logic [15:0]      BASE_STEP = 16'(LINE_BYTES);
  localparam logic [15:0]      RAM_END   = 16'(RAM_DEPTH);

  logic [7:0]       r_dat;
  logic             r_hs, r_vs, r_den;
  logic             w_hs_fall, w_vs_fall, w_vs_rise, w_den_rise;
  cap_state_t       r_state, w_state_next;

  logic             w_cap, w_pix, w_bit, w_in_line;
  logic [CNT_W-1:0] r_x;
  logic [15:0]      r_base;
  logic             r_line_act;
  logic [7:0]       r_acc, w_acc_next;
  logic             w_wr;
  logic [15:0]      w_wr_addr;
  logic [7:0]       w_wr_data;
  logic [7:0]       r_mem [RAM_DEPTH];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_dat <= '0;
      r_hs  <= 1'b1;
      r_vs  <= 1'b1;
      r_den <= 1'b1;
    end else begin
      r_dat <= lcd_dat;
      r_hs  <= lcd_hsync;
      r_vs  <= lcd_vsync;
      r_den <= lcd_den;
    end
  end

  lcd_timing_meter u_meter (
    .clk        (clk),
    .resetn     (resetn),
    .i_hs       (r_hs),
    .i_vs       (r_vs),
    .i_den      (r_den),
    .o_hs_fall  (w_hs_fall),
    .o_vs_fall  (w_vs_fall),
    .o_vs_rise  (w_vs_rise),
    .o_den_rise (w_den_rise),
    .o_h_total  (h_total),
    .o_h_active (h_active),
    .o_v_total  (v_total),
    .o_v_active (v_active)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (arm)       w_state_next = WAIT_VS;
      WAIT_VS: if (w_vs_rise) w_state_next = CAPTURE;
      CAPTURE: if (w_vs_fall) w_state_next = DONE;
      DONE:                   w_state_next = IDLE;
      default:                w_state_next = IDLE;
    endcase
  end

  always_comb begin
    busy       = (r_state == WAIT_VS) || (r_state == CAPTURE);
    frame_done = (r_state == DONE);
  end

  assign w_cap      = (r_state == CAPTURE);
  assign w_pix      = w_cap & ~r_den;
  assign w_bit      = (r_dat >= THRESH);
  assign w_in_line  = (r_x < LINE_PX);
  assign w_acc_next = r_acc | (8'(w_bit) << (3'd7 - r_x[2:0]));

  // Full byte on the eighth pixel, or a zero-padded partial byte when the run ends.
  always_comb begin
    w_wr      = 1'b0;
    w_wr_data = w_acc_next;
    w_wr_addr = r_base + {9'd0, r_x[9:3]};
    if (w_pix && w_in_line && (r_x[2:0] == 3'd7)) begin
      w_wr = 1'b1;
    end else if (w_cap && w_den_rise && w_in_line && (r_x[2:0] != 3'd0)) begin
      w_wr      = 1'b1;
      w_wr_data = r_acc;
    end
    if (w_wr_addr >= RAM_END) w_wr = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_x        <= '0;
      r_base     <= '0;
      r_line_act <= 1'b0;
      r_acc      <= '0;
    end else if (r_state == WAIT_VS) begin
      r_x        <= '0;
      r_base     <= '0;
      r_line_act <= 1'b0;
      r_acc      <= '0;
    end else if (w_cap) begin
      if (w_pix && w_in_line) r_acc <= (r_x[2:0] == 3'd7) ? 8'h00 : w_acc_next;
      else if (w_den_rise)    r_acc <= 8'h00;
      if (w_hs_fall) begin
        r_x        <= '0;
        r_line_act <= 1'b0;
        if (r_line_act) r_base <= r_base + BASE_STEP;
      end else if (w_pix) begin
        r_x        <= sat_inc(r_x);
        r_line_act <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[w_wr_addr[AW-1:0]] <= w_wr_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     cap_out <= '0;
    else if (rd_cap) cap_out <= r_mem[addr];
  end

`ifdef CAPTURE_CRC_EN
  logic [15:0] r_crc_run, r_crc;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_crc_run <= CRC_INIT;
      r_crc     <= CRC_INIT;
    end else begin
      if (r_state == WAIT_VS) r_crc_run <= CRC_INIT;
      else if (w_pix)         r_crc_run <= crc16_byte(r_crc_run, r_dat);
      if (w_cap && w_vs_fall) r_crc <= r_crc_run;
    end
  end

  assign crc = r_crc;
`else
  assign crc = 16'h0000;
`endif

endmodule

// File: tb/tb_lcd_capture.sv
// tb/tb_lcd_capture.sv - directed self-checking bench for lcd_capture
// Expects crc from a local CRC model when built with CAPTURE_CRC_EN, else 0.
module tb_lcd_capture;

  localparam int HB = 10;

  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  lcd_dat;
  logic        lcd_hsync, lcd_vsync, lcd_den;
  logic        arm;
  logic        busy, frame_done;
  logic [9:0]  h_total, h_active, v_total, v_active;
  logic        rd_cap;
  logic [10:0] addr;
  logic [7:0]  cap_out;
  logic [15:0] crc;

  int          n_checks = 0;
  int          n_errors = 0;
  int          done_cnt = 0;
  int          done_base;
  int          mode;
  logic [7:0]  single_val;

  lcd_capture dut (
    .clk        (clk),
    .resetn     (resetn),
    .lcd_dat    (lcd_dat),
    .lcd_hsync  (lcd_hsync),
    .lcd_vsync  (lcd_vsync),
    .lcd_den    (lcd_den),
    .arm        (arm),
    .busy       (busy),
    .frame_done (frame_done),
    .h_total    (h_total),
    .h_active   (h_active),
    .v_total    (v_total),
    .v_active   (v_active),
    .rd_cap     (rd_cap),
    .addr       (addr),
    .cap_out    (cap_out),
    .crc        (crc)
  );

  always #20 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pix_val(input int x, input int y);
    case (mode)
      1:       return 8'hFF;
      2:       return (x == 9 && y == 1) ? single_val : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [15:0] golden_crc(input int nbytes, input logic [7:0] b);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int n = 0; n < nbytes; n++) begin
      c = c ^ {b, 8'h00};
      for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      lcd_hsync = 1'b1; lcd_vsync = 1'b1; lcd_den = 1'b1; lcd_dat = 8'h00;
    end
  endtask

  task automatic drive_line(input int h_tot, input int h_act, input bit vs_low, input bit act, input int y);
    for (int c = 0; c < h_tot; c++) begin
      @(negedge clk);
      lcd_hsync = (c < 8) ? 1'b0 : 1'b1;
      lcd_vsync = vs_low ? 1'b0 : 1'b1;
      if (act && c >= HB && c < HB + h_act) begin
        lcd_den = 1'b0;
        lcd_dat = pix_val(c - HB, y);
      end else begin
        lcd_den = 1'b1;
        lcd_dat = 8'h00;
      end
    end
  endtask

  // Lines 0-1 carry vsync low; visible lines start at line 3.
  task automatic gen_frame(input int h_tot, input int h_act, input int v_tot, input int v_act);
    for (int l = 0; l < v_tot; l++)
      drive_line(h_tot, h_act, (l < 2), (l >= 3 && l < 3 + v_act), l - 3);
  endtask

  task automatic end_frame(input int h_tot);
    drive_line(h_tot, 0, 1'b1, 1'b0, 0);
    idle(4);
  endtask

  task automatic pulse_arm();
    @(negedge clk); arm = 1'b1;
    @(negedge clk); arm = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [10:0] a, input logic [7:0] exp);
    @(negedge clk); rd_cap = 1'b1; addr = a;
    @(negedge clk); rd_cap = 1'b0;
    check_eq(tag, {24'd0, cap_out}, {24'd0, exp});
  endtask

  initial begin
    resetn = 1'b0; arm = 1'b0; rd_cap = 1'b0; addr = '0;
    lcd_hsync = 1'b1; lcd_vsync = 1'b1; lcd_den = 1'b1; lcd_dat = 8'h00;
    mode = 0; single_val = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check_eq("rst_h_total", {22'd0, h_total}, 32'd0);
    check_eq("rst_v_active", {22'd0, v_active}, 32'd0);
    check_eq("rst_cap_out", {24'd0, cap_out}, 32'd0);
`ifdef CAPTURE_CRC_EN
    check_eq("rst_crc", {16'd0, crc}, 32'hFFFF);
`else
    check_eq("rst_crc", {16'd0, crc}, 32'h0000);
`endif
    @(negedge clk); resetn = 1'b1;
    idle(4);

    // Timing measurement without capture
    gen_frame(408, 320, 20, 16);
    gen_frame(408, 320, 20, 16);
    end_frame(408);
    check_eq("meas_h_total", {22'd0, h_total}, 32'd408);
    check_eq("meas_h_active", {22'd0, h_active}, 32'd320);
    check_eq("meas_v_total", {22'd0, v_total}, 32'd20);
    check_eq("meas_v_active", {22'd0, v_active}, 32'd16);
    check_eq("meas_no_done", done_cnt, 32'd0);
    idle(1100);
    end_frame(48);
    check_eq("sat_h_total", {22'd0, h_total}, 32'd1023);
    check_eq("short_v_total", {22'd0, v_total}, 32'd1);
    check_eq("short_v_active", {22'd0, v_active}, 32'd0);
    gen_frame(48, 32, 262, 240);
    end_frame(48);
    check_eq("tall_h_total", {22'd0, h_total}, 32'd48);
    check_eq("tall_h_active", {22'd0, h_active}, 32'd32);
    check_eq("tall_v_total", {22'd0, v_total}, 32'd262);
    check_eq("tall_v_active", {22'd0, v_active}, 32'd240);

    // All-white capture, overflowing the RAM
    mode = 1; done_base = done_cnt;
    pulse_arm();
    check_eq("arm_busy", {31'd0, busy}, 32'd1);
    gen_frame(340, 320, 56, 52);
    end_frame(340);
    check_eq("white_done", done_cnt - done_base, 32'd1);
    check_eq("white_busy", {31'd0, busy}, 32'd0);
    rd_check("white_a0", 11'd0, 8'hFF);
    rd_check("white_a1999", 11'd1999, 8'hFF);
    rd_check("white_a2047", 11'd2047, 8'hFF);

    // Single pixel at x=9,y=1 on the threshold
    mode = 2; single_val = 8'h80;
    pulse_arm();
    gen_frame(340, 320, 8, 4);
    end_frame(340);
    rd_check("dot_a41", 11'd41, 8'h40);
    rd_check("dot_a40", 11'd40, 8'h00);
    rd_check("dot_a42", 11'd42, 8'h00);
    rd_check("dot_a1", 11'd1, 8'h00);
    rd_check("dot_a81", 11'd81, 8'h00);
    single_val = 8'h7F;
    pulse_arm();
    gen_frame(340, 320, 8, 4);
    end_frame(340);
    rd_check("dot7f_a41", 11'd41, 8'h00);

    // 13-pixel lines: one full byte and one padded byte
    mode = 1;
    pulse_arm();
    gen_frame(40, 13, 8, 4);
    end_frame(40);
    rd_check("run13_a0", 11'd0, 8'hFF);
    rd_check("run13_a1", 11'd1, 8'hF8);
    rd_check("run13_a2", 11'd2, 8'h00);
    rd_check("run13_a40", 11'd40, 8'hFF);
    rd_check("run13_a41", 11'd41, 8'hF8);

    // Reset in the middle of a capture, then a clean re-arm
    done_base = done_cnt;
    pulse_arm();
    fork
      gen_frame(40, 13, 8, 4);
      begin
        repeat (150) @(negedge clk);
        check_eq("mid_busy", {31'd0, busy}, 32'd1);
        resetn = 1'b0;
        #1;
        check_eq("rst_mid_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_mid_done", {31'd0, frame_done}, 32'd0);
      end
    join
    @(negedge clk); resetn = 1'b1;
    idle(4);
    check_eq("rst_no_done", done_cnt - done_base, 32'd0);
    mode = 0;
    pulse_arm();
    gen_frame(40, 13, 8, 4);
    end_frame(40);
    check_eq("rearm_done", done_cnt - done_base, 32'd1);
    rd_check("rearm_a0", 11'd0, 8'h00);
    rd_check("rearm_a1", 11'd1, 8'h00);
    rd_check("rearm_a41", 11'd41, 8'h00);
`ifdef CAPTURE_CRC_EN
    check_eq("crc_zero_frame", {16'd0, crc}, {16'd0, golden_crc(52, 8'h00)});
`else
    check_eq("crc_zero_frame", {16'd0, crc}, 32'h0000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
